instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch sequencer. Owns the program counter and issues word
//   reads to instruction memory over a req/ack handshake. Each fetched
//   instruction is presented to decode with a valid/ready handshake. Execute
//   redirects the PC on a taken branch or jump.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   fetch_en     in   run enable; low stops new requests (in-flight completes)
//   imem_req     out  read request to instruction memory
//   imem_addr    out  word address, stable while imem_req high
//   imem_ack     in   read complete; imem_rdata valid this cycle
//   imem_rdata   in   read data
//   instr        out  fetched instruction
//   instr_pc     out  address of instr
//   opcode       out  instr top 4 bits
//   instr_valid  out  instr/instr_pc/opcode valid
//   instr_ready  in   decode accepts (handshake = instr_valid & instr_ready)
//   redirect     in   taken branch/jump, single-cycle pulse
//   redirect_pc  in   new fetch address, sampled when redirect high
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ADDR_W-1:0]    r_pc;
  logic                 r_imem_req;
  logic [ADDR_W-1:0]    r_imem_addr;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic [3:0]           r_opcode;
  logic                 r_instr_valid;
  // Set when a redirect lands while a request is outstanding: the response
  // for that request belongs to the old path and must be dropped.
  logic                 r_kill;

  logic [ADDR_W-1:0]    w_pc_nxt;
  logic                 w_req_nxt;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]    w_ipc_nxt;
  logic [3:0]           w_op_nxt;
  logic                 w_vld_nxt;
  logic                 w_kill_nxt;

  logic                 w_hs;
  logic [ADDR_W-1:0]    w_tgt;
  logic [ADDR_W-1:0]    w_pc_inc;

  assign w_hs     = r_instr_valid & instr_ready;
  // A redirect arriving this cycle takes priority over the stored pc.
  assign w_tgt    = redirect ? redirect_pc : r_pc;
  assign w_pc_inc = r_imem_addr + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_en) w_state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (r_kill || redirect) w_state_nxt = fetch_en ? REQ : IDLE;
          else                    w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect || w_hs) w_state_nxt = fetch_en ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_imem_req;
    w_addr_nxt  = r_imem_addr;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_instr_pc;
    w_op_nxt    = r_opcode;
    w_vld_nxt   = r_instr_valid;
    w_kill_nxt  = r_kill;
    case (r_state)
      IDLE: begin
        if (redirect) w_pc_nxt = redirect_pc;
        if (fetch_en) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = w_tgt;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (r_kill || redirect) begin
            // Stale response: drop it and restart at the redirect target.
            w_kill_nxt = 1'b0;
            w_pc_nxt   = w_tgt;
            w_req_nxt  = fetch_en;
            if (fetch_en) w_addr_nxt = w_tgt;
          end else begin
            w_instr_nxt = imem_rdata;
            w_ipc_nxt   = r_imem_addr;
            w_op_nxt    = imem_rdata[INSTR_W-1 -: 4];
            w_vld_nxt   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_req_nxt   = 1'b0;
          end
        end else if (redirect) begin
          // Request must complete before the new path can start; remember
          // the latest target until then.
          w_kill_nxt = 1'b1;
          w_pc_nxt   = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          // A coincident handshake is still treated as accepted; either way
          // the presented instruction is withdrawn.
          w_vld_nxt = 1'b0;
          w_pc_nxt  = redirect_pc;
          w_req_nxt = fetch_en;
          if (fetch_en) w_addr_nxt = redirect_pc;
        end else if (w_hs) begin
          w_vld_nxt = 1'b0;
          w_req_nxt = fetch_en;
          if (fetch_en) w_addr_nxt = r_pc;
        end
      end
      default: begin
        w_req_nxt = 1'b0;
        w_vld_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= PC_RST;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= PC_RST;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_opcode      <= '0;
      r_instr_valid <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_imem_req    <= w_req_nxt;
      r_imem_addr   <= w_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_ipc_nxt;
      r_opcode      <= w_op_nxt;
      r_instr_valid <= w_vld_nxt;
      r_kill        <= w_kill_nxt;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_opcode;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit: a per-cycle vector table for
//   reset, sequential fetch, decode stall and redirect-in-HOLD; hand-written
//   sequences for a killed slow request, PC wrap with stop, and asynchronous
//   reset mid-request; then randomized traffic checked against a
//   transaction-level model of the instruction stream.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents: low half follows 16'h1000+a, upper half
  // varies the opcode.
  function automatic logic [15:0] mem(input logic [7:0] a);
    if (a < 8'h80) return 16'h1000 + {8'h00, a};
    else           return {a[3:0], 4'hA, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       fe;
    logic       ack;
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       ereq;
    logic [7:0] eaddr;
    logic       evld;
    logic [7:0] epc;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic fe, input logic ack, input logic rdy,
                              input logic redir, input logic [7:0] rpc,
                              input logic ereq, input logic [7:0] eaddr,
                              input logic evld, input logic [7:0] epc);
    vec_t v;
    v.fe = fe; v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
    tv.push_back(v);
  endfunction

  // random-phase model state
  logic [7:0]  exp_next;
  logic        p_req, p_ack, p_valid, p_rdy, p_redir;
  logic [7:0]  p_addr;
  logic [15:0] p_instr;
  int          lat;
  int          presented;

  initial begin
    // ---------------- vector table ----------------
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00);   // IDLE: stray ack ignored
    for (int k = 0; k < 6; k++) begin
      add(1, 1, 0, 0, 8'h00, 1, 8'(k), 0, 8'h00); // zero-wait request
      if (k == 3) repeat (5) add(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'd3);
      if (k == 5) add(1, 0, 0, 1, 8'h40, 0, 8'h00, 1, 8'd5);
      else        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 8'(k));
    end
    add(1, 1, 0, 0, 8'h00, 1, 8'h40, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h40);

    rst_n = 1'b0; fetch_en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_req), 0);
    chk("rst_addr",  32'(imem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_ipc",   32'(instr_pc), 0);
    chk("rst_op",    32'(opcode), 0);
    chk("rst_vld",   32'(instr_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      tick();
      fetch_en    = tv[i].fe;
      imem_ack    = tv[i].ack;
      imem_rdata  = tv[i].ack ? mem(tv[i].eaddr) : 16'hDEAD;
      instr_ready = tv[i].rdy;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      chk("tv_req", 32'(imem_req), 32'(tv[i].ereq));
      if (tv[i].ereq) chk("tv_addr", 32'(imem_addr), 32'(tv[i].eaddr));
      chk("tv_vld", 32'(instr_valid), 32'(tv[i].evld));
      if (tv[i].evld) begin
        chk("tv_ipc",   32'(instr_pc), 32'(tv[i].epc));
        chk("tv_instr", 32'(instr), 32'(mem(tv[i].epc)));
        chk("tv_op",    32'(opcode), 32'(mem(tv[i].epc) >> 12));
      end
    end

    // ---------------- redirect during a 3-cycle request ----------------
    tick();
    imem_ack = 0; redirect = 1; redirect_pc = 8'h07; instr_ready = 1;
    chk("a_hold_vld", 32'(instr_valid), 1);
    tick();
    redirect = 0; instr_ready = 0;
    chk("a_req7", 32'(imem_req), 1);
    chk("a_addr7", 32'(imem_addr), 8'h07);
    tick();
    redirect = 1; redirect_pc = 8'h20;
    chk("a_addr7_held", 32'(imem_addr), 8'h07);
    chk("a_vld0_1", 32'(instr_valid), 0);
    tick();
    redirect = 0; imem_ack = 1; imem_rdata = mem(8'h07);
    chk("a_req_still", 32'(imem_req), 1);
    chk("a_vld0_2", 32'(instr_valid), 0);
    tick();
    imem_ack = 1; imem_rdata = mem(8'h20);
    chk("a_killed_vld", 32'(instr_valid), 0);
    chk("a_req20", 32'(imem_req), 1);
    chk("a_addr20", 32'(imem_addr), 8'h20);
    tick();
    imem_ack = 0;
    chk("a_vld20", 32'(instr_valid), 1);
    chk("a_ipc20", 32'(instr_pc), 8'h20);
    chk("a_instr20", 32'(instr), 32'(mem(8'h20)));

    // ---------------- wrap and stop ----------------
    redirect = 1; redirect_pc = 8'hFE; instr_ready = 1;
    tick();
    redirect = 0; instr_ready = 0; imem_ack = 1; imem_rdata = mem(8'hFE);
    chk("w_addrFE", 32'(imem_addr), 8'hFE);
    tick();
    imem_ack = 0; instr_ready = 1;
    chk("w_ipcFE", 32'(instr_pc), 8'hFE);
    tick();
    instr_ready = 0; imem_ack = 1; imem_rdata = mem(8'hFF);
    chk("w_addrFF", 32'(imem_addr), 8'hFF);
    tick();
    imem_ack = 0; instr_ready = 1;
    chk("w_ipcFF", 32'(instr_pc), 8'hFF);
    tick();
    instr_ready = 0; fetch_en = 0;
    chk("w_req00", 32'(imem_req), 1);
    chk("w_addr00", 32'(imem_addr), 8'h00);
    tick();
    imem_ack = 1; imem_rdata = mem(8'h00);
    chk("w_req00_held", 32'(imem_req), 1);
    tick();
    imem_ack = 0; instr_ready = 1;
    chk("w_vld00", 32'(instr_valid), 1);
    chk("w_ipc00", 32'(instr_pc), 8'h00);
    chk("w_instr00", 32'(instr), 32'(mem(8'h00)));
    tick();
    instr_ready = 0;
    chk("w_idle_vld", 32'(instr_valid), 0);
    chk("w_idle_req", 32'(imem_req), 0);
    tick();
    chk("w_idle_req2", 32'(imem_req), 0);

    // ---------------- async reset mid-request ----------------
    fetch_en = 1;
    tick();
    chk("r_req1", 32'(imem_req), 1);
    chk("r_addr1", 32'(imem_addr), 8'h01);
    #2;
    rst_n = 0; fetch_en = 0;
    #1;
    chk("r_async_req", 32'(imem_req), 0);
    chk("r_async_vld", 32'(instr_valid), 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    fetch_en = 1;
    chk("r_idle", 32'(imem_req), 0);
    tick();
    chk("r_first_req", 32'(imem_req), 1);
    chk("r_first_addr", 32'(imem_addr), 8'h00);

    // ---------------- randomized traffic ----------------
    rst_n = 0; fetch_en = 0; imem_ack = 0; redirect = 0; instr_ready = 0;
    tick();
    @(negedge clk);
    rst_n = 1;
    exp_next = 8'h00;
    p_req = 0; p_ack = 0; p_valid = 0; p_rdy = 0; p_redir = 0;
    p_addr = '0; p_instr = '0; lat = -1; presented = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk("rnd_req_excl", 32'(imem_req & instr_valid), 0);
      if (imem_req && (!p_req || p_ack))
        chk("rnd_req_addr", 32'(imem_addr), 32'(exp_next));
      if (imem_req && p_req && !p_ack)
        chk("rnd_addr_stable", 32'(imem_addr), 32'(p_addr));
      if (p_valid && !p_rdy && !p_redir) begin
        chk("rnd_hold_vld", 32'(instr_valid), 1);
        chk("rnd_hold_instr", 32'(instr), 32'(p_instr));
      end
      if (p_valid && (p_rdy || p_redir))
        chk("rnd_vld_drop", 32'(instr_valid), 0);
      if (instr_valid && !p_valid) begin
        chk("rnd_ipc", 32'(instr_pc), 32'(exp_next));
        chk("rnd_instr", 32'(instr), 32'(mem(instr_pc)));
        chk("rnd_op", 32'(opcode), 32'(instr[15:12]));
        exp_next = instr_pc + 8'd1;
        presented++;
      end
      fetch_en    = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 8'($urandom);
      imem_ack    = 1'b0;
      imem_rdata  = 16'hBEEF;
      if (imem_req) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem(imem_addr);
          lat        = -1;
        end else begin
          lat--;
        end
      end else begin
        lat = -1;
      end
      if (redirect) exp_next = redirect_pc;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = instr_valid; p_rdy = instr_ready; p_redir = redirect;
      p_instr = instr;
    end
    chk("rnd_progress", 32'(presented > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
